// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous single-port RAM.
// One access in flight at a time; per-port registered read data and one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state_q, state_d;
  logic              grant_vld, grant_port;
  logic              owner_q, last_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Tie goes to the port that was not served last.
  always_comb begin
    grant_vld  = m0_req_i | m1_req_i;
    grant_port = 1'b0;
    if (m0_req_i && m1_req_i) begin
      grant_port = ~last_q;
    end else if (m1_req_i) begin
      grant_port = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = ISSUE;
      ISSUE:   state_d = we_q ? ACK : WAIT;
      WAIT:    if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q <= grant_port;
            last_q  <= grant_port;
            we_q    <= grant_port ? m1_we_i    : m0_we_i;
            addr_q  <= grant_port ? m1_addr_i  : m0_addr_i;
            wdata_q <= grant_port ? m1_wdata_i : m0_wdata_i;
          end
        end
        ISSUE: begin
          if (!we_q) cnt_q <= CNT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q) rdata1_q <= mem_rdata_i;
            else         rdata0_q <= mem_rdata_i;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en_o    = (state_q == ISSUE);
  assign mem_we_o    = (state_q == ISSUE) & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign m0_ack_o    = (state_q == ACK) & ~owner_q;
  assign m1_ack_o    = (state_q == ACK) &  owner_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3 on one clock and reset,
// each backed by a RAM model; acks are checked against a scoreboard of expected completions.
module tb_mem_port_arbiter;

  typedef struct {
    int         inst;
    int         port;
    logic [7:0] rdata;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic       req   [3][2];
  logic       we    [3][2];
  logic [7:0] addr  [3][2];
  logic [7:0] wdata [3][2];
  logic       ack   [3][2];
  logic [7:0] rdata [3][2];
  logic       mem_en    [3];
  logic       mem_we    [3];
  logic [7:0] mem_addr  [3];
  logic [7:0] mem_wdata [3];
  logic [7:0] mem_rdata [3];
  logic       busy      [3];
  logic       owner     [3];

  logic [7:0] ram    [3][256];
  logic [7:0] rpipe  [3][4];
  logic [7:0] shadow [3][256];
  logic [7:0] exp_rd [3][2];
  int         last_srv [3];
  sb_t        sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(g + 1)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .m0_req_i    (req[g][0]),
      .m0_we_i     (we[g][0]),
      .m0_addr_i   (addr[g][0]),
      .m0_wdata_i  (wdata[g][0]),
      .m0_ack_o    (ack[g][0]),
      .m0_rdata_o  (rdata[g][0]),
      .m1_req_i    (req[g][1]),
      .m1_we_i     (we[g][1]),
      .m1_addr_i   (addr[g][1]),
      .m1_wdata_i  (wdata[g][1]),
      .m1_ack_o    (ack[g][1]),
      .m1_rdata_o  (rdata[g][1]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g]),
      .busy_o      (busy[g]),
      .owner_o     (owner[g])
    );
  end

  // RAM model: instance k has read latency k+1 cycles after the enable cycle.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_en[k] && mem_we[k]) ram[k][mem_addr[k]] <= mem_wdata[k];
      rpipe[k][0] <= ram[k][mem_addr[k]];
      for (int s = 1; s < 4; s++) rpipe[k][s] <= rpipe[k][s-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) mem_rdata[k] = rpipe[k][k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      last_srv[k] = 1;
      for (int p = 0; p < 2; p++) exp_rd[k][p] = 8'h00;
    end
    sb.delete();
  endtask

  task automatic check_all_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_en"},    mem_en[k],    0);
      chk({tag, "_we"},    mem_we[k],    0);
      chk({tag, "_addr"},  mem_addr[k],  0);
      chk({tag, "_wdata"}, mem_wdata[k], 0);
      chk({tag, "_busy"},  busy[k],      0);
      chk({tag, "_owner"}, owner[k],     0);
      for (int p = 0; p < 2; p++) begin
        chk({tag, "_ack"},   ack[k][p],   0);
        chk({tag, "_rdata"}, rdata[k][p], 0);
      end
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    clear_model();
    #1;
    check_all_reset("rst_pulse");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Single-port access; grant cycle is the cycle in which the task is called.
  task automatic do_access(input int i, input int p, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input int exp_lat, input bit chg);
    sb_t e;
    int  n;
    bit  got;
    n   = 0;
    got = 0;
    e.inst  = i;
    e.port  = p;
    e.rdata = w ? exp_rd[i][p] : shadow[i][a];
    if (w) shadow[i][a] = d;
    sb.push_back(e);
    we[i][p]    = w;
    addr[i][p]  = a;
    wdata[i][p] = d;
    req[i][p]   = 1'b1;
    while (!got && n < 20) begin
      tick();
      n++;
      chk("addr_held", mem_addr[i], a);
      chk("other_ack", ack[i][1-p], 0);
      if (n == 1) begin
        chk("issue_en",    mem_en[i],    1);
        chk("issue_we",    mem_we[i],    w);
        chk("issue_wdata", mem_wdata[i], d);
        chk("issue_owner", owner[i],     p);
        if (chg) begin
          addr[i][p] = a ^ 8'h10;
          req[i][p]  = 1'b0;
        end
      end else begin
        chk("idle_en", mem_en[i], 0);
        chk("idle_we", mem_we[i], 0);
      end
      if (ack[i][p]) got = 1;
      else chk("busy_mid", busy[i], 1);
    end
    chk("ack_seen", got, 1);
    chk("ack_latency", n, exp_lat);
    if (got) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rdata", rdata[i][p], e.rdata);
        exp_rd[i][p] = e.rdata;
      end
      chk("other_rdata", rdata[i][1-p], exp_rd[i][1-p]);
      last_srv[i] = p;
    end
    req[i][p] = 1'b0;
    tick();
    chk("ack_pulse", ack[i][p], 0);
    chk("busy_after", busy[i], 0);
    chk("owner_hold", owner[i], p);
    sb.delete();
  endtask

  // Both ports request writes; in stream mode m1 never drops req and m0 re-raises
  // in the IDLE cycle after each ack, so every arbitration is a tie.
  task automatic arb_run(input int i, input int nacks, input bit stream);
    sb_t        e;
    int         n;
    int         got;
    int         nxt;
    bit         raise0;
    logic [7:0] last_iss;
    n        = 0;
    got      = 0;
    raise0   = 0;
    last_iss = 8'h00;
    we[i][0] = 1'b1;  addr[i][0] = 8'h01;  wdata[i][0] = 8'h11;
    we[i][1] = 1'b1;  addr[i][1] = 8'h02;  wdata[i][1] = 8'h22;
    for (int k = 0; k < nacks; k++) begin
      nxt = 1 - last_srv[i];
      e.inst  = i;
      e.port  = nxt;
      e.rdata = exp_rd[i][nxt];
      sb.push_back(e);
      last_srv[i] = nxt;
    end
    req[i][0] = 1'b1;
    req[i][1] = 1'b1;
    while (got < nacks && n < 60) begin
      tick();
      n++;
      if (raise0) begin
        req[i][0] = 1'b1;
        raise0    = 0;
      end
      if (mem_en[i]) last_iss = mem_addr[i];
      chk("dual_ack", ack[i][0] & ack[i][1], 0);
      for (int p = 0; p < 2; p++) begin
        if (ack[i][p]) begin
          got++;
          chk("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("arb_order", p, e.port);
            chk("arb_rdata", rdata[i][p], e.rdata);
          end
          chk("arb_issued_addr", last_iss, addr[i][p]);
          if (p == 0 || !stream) req[i][p] = 1'b0;
          if (p == 0 && stream) raise0 = 1;
        end
      end
    end
    chk("arb_done", got, nacks);
    req[i][0] = 1'b0;
    req[i][1] = 1'b0;
    tick();
    chk("arb_idle", busy[i], 0);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p]   = 1'b0;
        we[k][p]    = 1'b0;
        addr[k][p]  = 8'h00;
        wdata[k][p] = 8'h00;
      end
    end
    clear_model();

    // Asynchronous reset asserted between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_all_reset("rst_async");
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        chk("idle_busy", busy[k], 0);
        chk("idle_en", mem_en[k], 0);
      end
    end

    // MEM_LAT=1 write from port 0
    do_access(0, 0, 1'b1, 8'h10, 8'hA5, 2, 0);

    // MEM_LAT=2: seed RAM then port 1 read
    do_access(1, 0, 1'b1, 8'h10, 8'hA5, 2, 0);
    do_access(1, 1, 1'b0, 8'h10, 8'h00, 4, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("m1_rdata_hold", rdata[1][1], 8'hA5);
      chk("m0_rdata_zero", rdata[1][0], 8'h00);
    end

    // Requester changes address and drops req during ISSUE
    do_access(0, 0, 1'b1, 8'h20, 8'h5C, 2, 0);
    do_access(0, 0, 1'b0, 8'h20, 8'h00, 3, 1);

    // Round-robin ties from a fresh reset
    reset_pulse();
    arb_run(0, 2, 0);
    arb_run(0, 2, 0);
    arb_run(0, 4, 1);

    // MEM_LAT=3: reset during WAIT aborts the read, pending m1 read follows
    do_access(2, 0, 1'b1, 8'h40, 8'h77, 2, 0);
    we[2][0]   = 1'b0;
    addr[2][0] = 8'h40;
    req[2][0]  = 1'b1;
    tick();
    chk("lat3_issue", mem_en[2], 1);
    we[2][1]   = 1'b0;
    addr[2][1] = 8'h40;
    req[2][1]  = 1'b1;
    tick();
    chk("lat3_wait_ack", ack[2][0], 0);
    tick();
    chk("lat3_wait_busy", busy[2], 1);
    rst_n     = 1'b0;
    req[2][0] = 1'b0;
    clear_model();
    #1;
    check_all_reset("rst_mid_read");
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_no_ack0", ack[2][0], 0);
      chk("rst_no_ack1", ack[2][1], 0);
    end
    rst_n = 1'b1;
    do_access(2, 1, 1'b0, 8'h40, 8'h00, 5, 0);
    chk("aborted_rdata", rdata[2][0], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
